// File: rtl/bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : bus_bridge
//  Brief    : MEM-stage bus responder. Splits CPU accesses between DRAM and a
//             peripheral page at 0xFFFFF000 (DIGIT, timer, LED, SW, BTN), and
//             drives a multiplexed seven-segment display from DIGIT.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_bridge #(
  parameter int SCAN_DIV = 50000,
  parameter int DRAM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         seg_en,
  output logic [7:0]         seg_code
);

  localparam int SCNT_W = $clog2(SCAN_DIV);

  // Word offsets (byte offset >> 2) inside the peripheral page
  localparam logic [9:0] OFF_DIGIT = 10'h000;
  localparam logic [9:0] OFF_TCNT  = 10'h008;
  localparam logic [9:0] OFF_TDIV  = 10'h009;
  localparam logic [9:0] OFF_LED   = 10'h018;
  localparam logic [9:0] OFF_SW    = 10'h01C;
  localparam logic [9:0] OFF_BTN   = 10'h01E;

  logic              periph;
  logic [9:0]        word_off;
  logic              pwen;
  logic              unused_addr_lsbs;

  logic [31:0]       digit;
  logic [31:0]       tcnt;
  logic [31:0]       tdiv;
  logic [31:0]       pcnt;
  logic [31:0]       plim;
  logic              tick;
  logic [23:0]       sw_s1;
  logic [23:0]       sw_s2;
  logic [4:0]        btn_s1;
  logic [4:0]        btn_s2;
  logic [SCNT_W-1:0] scnt;
  logic [2:0]        sidx;

  assign periph           = (Bus_addr[31:12] == 20'hFFFFF);
  assign word_off         = Bus_addr[11:2];
  assign pwen             = Bus_wen & periph;
  assign unused_addr_lsbs = ^Bus_addr[1:0];

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wen   = Bus_wen & ~periph;
  assign dram_wdata = Bus_wdata;

  // A divisor of 0 behaves as 1, so the prescaler limit saturates at 0
  assign plim = (tdiv == 32'd0) ? 32'd0 : (tdiv - 32'd1);
  assign tick = (pcnt == plim);

  // Active-low seven-segment patterns {dp,g,f,e,d,c,b,a}, dp always off
  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // Same-cycle load data; reflects register state before any concurrent write
  always_comb begin
    Bus_rdata = 32'd0;
    if (!periph) begin
      Bus_rdata = dram_rdata;
    end else begin
      case (word_off)
        OFF_DIGIT: Bus_rdata = digit;
        OFF_TCNT:  Bus_rdata = tcnt;
        OFF_TDIV:  Bus_rdata = tdiv;
        OFF_LED:   Bus_rdata = {8'd0, led};
        OFF_SW:    Bus_rdata = {8'd0, sw_s2};
        OFF_BTN:   Bus_rdata = {27'd0, btn_s2};
        default:   Bus_rdata = 32'd0;
      endcase
    end
  end

  // Plain writable registers: DIGIT and LED
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= 32'd0;
      led   <= 24'd0;
    end else begin
      if (pwen && word_off == OFF_DIGIT) digit <= Bus_wdata;
      if (pwen && word_off == OFF_LED)   led   <= Bus_wdata[23:0];
    end
  end

  // Prescaled timer; a TCNT write wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt <= 32'd0;
      tdiv <= 32'd0;
      pcnt <= 32'd0;
    end else begin
      if (pwen && word_off == OFF_TCNT) begin
        tcnt <= Bus_wdata;
        pcnt <= 32'd0;
      end else begin
        if (tick) tcnt <= tcnt + 32'd1;
        if ((pwen && word_off == OFF_TDIV) || tick) pcnt <= 32'd0;
        else                                        pcnt <= pcnt + 32'd1;
      end
      if (pwen && word_off == OFF_TDIV) tdiv <= Bus_wdata;
    end
  end

  // Two-flop synchronizers for the asynchronous switch and button inputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1  <= 24'd0;
      sw_s2  <= 24'd0;
      btn_s1 <= 5'd0;
      btn_s2 <= 5'd0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // Display scan: dwell SCAN_DIV cycles per digit, register the drive lines
  always_ff @(posedge clk) begin
    if (!rst) begin
      scnt     <= '0;
      sidx     <= 3'd0;
      seg_en   <= 8'hFF;
      seg_code <= 8'hFF;
    end else begin
      if (scnt == SCNT_W'(SCAN_DIV - 1)) begin
        scnt <= '0;
        sidx <= sidx + 3'd1;
      end else begin
        scnt <= scnt + 1'b1;
      end
      seg_en   <= ~(8'b1 << sidx);
      seg_code <= hex7(digit[{sidx, 2'b00} +: 4]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_bridge
//  Brief    : Self-checking bench for bus_bridge. Directed test-plan sequences
//             with literal expectations, then randomized traffic compared each
//             cycle against a behavioural model of the register page.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_bridge;

  localparam int SCAN_DIV = 4;
  localparam int DRAM_AW  = 14;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        Bus_addr = 32'd0;
  logic               Bus_wen = 1'b0;
  logic [31:0]        Bus_wdata = 32'd0;
  logic [31:0]        Bus_rdata;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_wen;
  logic [31:0]        dram_wdata;
  logic [31:0]        dram_rdata = 32'd0;
  logic [23:0]        sw = 24'd0;
  logic [4:0]         btn = 5'd0;
  logic [23:0]        led;
  logic [7:0]         seg_en;
  logic [7:0]         seg_code;

  bus_bridge #(.SCAN_DIV(SCAN_DIV), .DRAM_AW(DRAM_AW)) dut (
    .clk(clk), .rst(rst),
    .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata),
    .Bus_rdata(Bus_rdata),
    .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .sw(sw), .btn(btn), .led(led), .seg_en(seg_en), .seg_code(seg_code)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] seg_lut [16];

  // Behavioural model state
  bit          m_valid = 1'b0;
  logic [31:0] m_digit, m_tcnt, m_tdiv;
  logic [23:0] m_led, m_sw1, m_sw2;
  logic [4:0]  m_b1, m_b2;
  int          m_since;   // edges since the prescaler was last cleared
  int          m_edges;   // edges since reset released
  logic [7:0]  m_seg_en, m_seg_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_rdata();
    if (Bus_addr[31:12] != 20'hFFFFF) return dram_rdata;
    case ({Bus_addr[11:2], 2'b00})
      12'h000: return m_digit;
      12'h020: return m_tcnt;
      12'h024: return m_tdiv;
      12'h060: return {8'd0, m_led};
      12'h070: return {8'd0, m_sw2};
      12'h078: return {27'd0, m_b2};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all();
    logic periph;
    if (!m_valid) return;
    periph = (Bus_addr[31:12] == 20'hFFFFF);
    chk("rdata",      Bus_rdata, exp_rdata());
    chk("dram_wen",   {31'd0, dram_wen}, {31'd0, Bus_wen & ~periph});
    chk("dram_addr",  {18'd0, dram_addr}, {18'd0, Bus_addr[15:2]});
    chk("dram_wdata", dram_wdata, Bus_wdata);
    chk("led",        {8'd0, led}, {8'd0, m_led});
    chk("seg_en",     {24'd0, seg_en}, {24'd0, m_seg_en});
    chk("seg_code",   {24'd0, seg_code}, {24'd0, m_seg_code});
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled
  task automatic model_edge();
    logic   wr;
    logic [11:0] off;
    int     idx;
    longint div;
    bit     tick;
    if (!rst) begin
      m_digit = 0; m_tcnt = 0; m_tdiv = 0; m_led = 0;
      m_sw1 = 0; m_sw2 = 0; m_b1 = 0; m_b2 = 0;
      m_since = 0; m_edges = 0;
      m_seg_en = 8'hFF; m_seg_code = 8'hFF;
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    wr  = Bus_wen && (Bus_addr[31:12] == 20'hFFFFF);
    off = {Bus_addr[11:2], 2'b00};
    idx = (m_edges / SCAN_DIV) % 8;
    m_seg_en   = ~(8'h01 << idx);
    m_seg_code = seg_lut[(m_digit >> (4 * idx)) & 32'hF];
    m_edges++;
    div  = (m_tdiv == 0) ? 64'd1 : longint'(m_tdiv);
    tick = ((longint'(m_since) + 1) % div) == 0;
    if (wr && off == 12'h020) begin
      m_tcnt  = Bus_wdata;
      m_since = 0;
    end else begin
      if (tick) m_tcnt = m_tcnt + 32'd1;
      if (wr && off == 12'h024) begin
        m_tdiv  = Bus_wdata;
        m_since = 0;
      end else begin
        m_since++;
      end
    end
    if (wr && off == 12'h000) m_digit = Bus_wdata;
    if (wr && off == 12'h060) m_led   = Bus_wdata[23:0];
    m_sw2 = m_sw1; m_sw1 = sw;
    m_b2  = m_b1;  m_b1  = btn;
  endtask

  // One bus cycle: compare mid-cycle, then step model at the edge
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set(input logic [31:0] a, input logic w, input logic [31:0] d);
    Bus_addr = a; Bus_wen = w; Bus_wdata = d;
    #1;
  endtask

  initial begin
    seg_lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reset
    rst = 1'b0;
    cycle(); cycle();
    chk("reset_seg_en", {24'd0, seg_en}, 32'hFF);
    chk("reset_led", {8'd0, led}, 32'd0);
    rst = 1'b1;
    set(32'hFFFFF020, 1'b0, 32'd0);
    chk("reset_tcnt", Bus_rdata, 32'd0);
    // Leave TDIV at a large value so the timer stays still during directed tests
    set(32'hFFFFF024, 1'b1, 32'd1000); cycle();

    // DRAM pass-through
    set(32'h00000104, 1'b1, 32'h12345678);
    chk("dram_wr_wen", {31'd0, dram_wen}, 32'd1);
    chk("dram_wr_addr", {18'd0, dram_addr}, 32'h41);
    cycle();
    dram_rdata = 32'hCAFEBABE;
    set(32'h00000104, 1'b0, 32'd0);
    chk("dram_rd", Bus_rdata, 32'hCAFEBABE);
    cycle();

    // LED
    set(32'hFFFFF060, 1'b1, 32'hFFABCDEF);
    chk("led_wr_dram_wen", {31'd0, dram_wen}, 32'd0);
    cycle();
    chk("led_out", {8'd0, led}, 32'h00ABCDEF);
    set(32'hFFFFF060, 1'b0, 32'd0);
    chk("led_rd", Bus_rdata, 32'h00ABCDEF);
    set(32'hFFFFF100, 1'b0, 32'd0);
    chk("unmapped_rd", Bus_rdata, 32'd0);
    cycle();

    // Timer prescale
    set(32'hFFFFF024, 1'b1, 32'd3);  cycle();
    set(32'hFFFFF020, 1'b1, 32'd10); cycle();
    set(32'hFFFFF020, 1'b0, 32'd0);
    chk("tcnt_e0", Bus_rdata, 32'd10);
    repeat (3) cycle();
    chk("tcnt_e3", Bus_rdata, 32'd11);
    repeat (3) cycle();
    chk("tcnt_e6", Bus_rdata, 32'd12);
    // Collision: write in the cycle whose edge would increment (edge +9)
    repeat (2) cycle();
    set(32'hFFFFF020, 1'b1, 32'h55); cycle();
    set(32'hFFFFF020, 1'b0, 32'd0);
    chk("collide", Bus_rdata, 32'h55);
    repeat (2) cycle();
    chk("collide_hold", Bus_rdata, 32'h55);
    cycle();
    chk("collide_next", Bus_rdata, 32'h56);
    // Wrap
    set(32'hFFFFF024, 1'b1, 32'd1); cycle();
    set(32'hFFFFF020, 1'b1, 32'hFFFFFFFF); cycle();
    set(32'hFFFFF020, 1'b0, 32'd0);
    chk("wrap_a", Bus_rdata, 32'hFFFFFFFF);
    cycle();
    chk("wrap_b", Bus_rdata, 32'd0);

    // Synchronizer
    sw = 24'hA5A5A5;
    set(32'hFFFFF070, 1'b0, 32'd0);
    chk("sync_e0", Bus_rdata, 32'd0);
    cycle();
    chk("sync_e1", Bus_rdata, 32'd0);
    cycle();
    chk("sync_e2", Bus_rdata, 32'h00A5A5A5);

    // Scan and mid-scan reset
    rst = 1'b0; set(32'd0, 1'b0, 32'd0); cycle();
    rst = 1'b1;
    set(32'hFFFFF000, 1'b1, 32'h76543210); cycle();
    chk("scan1_en", {24'd0, seg_en}, 32'hFE);
    chk("scan1_code", {24'd0, seg_code}, 32'hC0);
    set(32'hFFFFF060, 1'b1, 32'h123456);
    repeat (4) cycle();
    set(32'd0, 1'b0, 32'd0);
    chk("scan5_en", {24'd0, seg_en}, 32'hFD);
    chk("scan5_code", {24'd0, seg_code}, 32'hF9);
    repeat (4) cycle();
    chk("scan9_en", {24'd0, seg_en}, 32'hFB);
    chk("scan9_code", {24'd0, seg_code}, 32'hA4);
    repeat (2) cycle();
    rst = 1'b0; cycle();
    rst = 1'b1;
    chk("rst_seg_en", {24'd0, seg_en}, 32'hFF);
    chk("rst_led", {8'd0, led}, 32'd0);
    set(32'hFFFFF020, 1'b0, 32'd0);
    chk("rst_tcnt", Bus_rdata, 32'd0);
    cycle();
    chk("restart_en", {24'd0, seg_en}, 32'hFE);
    chk("restart_code", {24'd0, seg_code}, 32'hC0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [11:0] offs [9];
      logic [31:0] a;
      offs = '{12'h000, 12'h020, 12'h024, 12'h060, 12'h070, 12'h078,
               12'h004, 12'h100, 12'hFFC};
      if ($urandom_range(0, 9) < 4) begin
        a = $urandom;
        if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
      end else begin
        a = {20'hFFFFF, offs[$urandom_range(0, 8)]} | 32'($urandom_range(0, 3));
      end
      Bus_addr   = a;
      Bus_wen    = 1'($urandom_range(0, 1));
      Bus_wdata  = ({a[11:2], 2'b00} == 12'h024) ? 32'($urandom_range(0, 4)) : $urandom;
      dram_rdata = $urandom;
      if ($urandom_range(0, 7) == 0) sw  = 24'($urandom);
      if ($urandom_range(0, 7) == 0) btn = 5'($urandom);
      rst = ($urandom_range(0, 79) != 0);
      #1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_bridge.md
# bus_bridge

Bus responder between the pipelined CPU's MEM-stage data port and the system's data memory and peripherals. Decodes each bus address: ordinary addresses pass through to DRAM, while the top 4 KiB page holds memory-mapped peripheral registers. Those registers are an LED register, synchronized switch and button inputs, a prescaled timer, and a seven-segment display register with its own multiplexed scan driver. Reads are answered in the same cycle because the CPU samples `Bus_rdata` combinationally in MEM. Writes commit on the clock edge that ends the MEM cycle.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each seven-segment digit stays lit (must be ≥ 2).
- `DRAM_AW`, default 14: DRAM word-address width.

Ports:
- `clk`  input  1: system clock; single clock domain.
- `rst`  input  1: synchronous, active-low reset.
- `Bus_addr`  input  32: byte address from the CPU.
- `Bus_wen`  input  1: write strobe, one cycle per store.
- `Bus_wdata`  input  32: store data.
- `Bus_rdata`  output  32: load data, combinational.
- `dram_addr`  output  DRAM_AW: equal to `Bus_addr[DRAM_AW+1:2]`.
- `dram_wen`  output  1: DRAM write enable, combinational.
- `dram_wdata`  output  32: equal to `Bus_wdata`.
- `dram_rdata`  input  32: DRAM read data, combinational.
- `sw`  input  24: asynchronous switch inputs.
- `btn`  input  5: asynchronous button inputs.
- `led`  output  24: LED register value.
- `seg_en`  output  8: digit enables, active-low, registered.
- `seg_code`  output  8: segment pattern {dp,g,f,e,d,c,b,a}, active-low, registered.

## Operation
- **Decode.** A bus access is a peripheral access when `Bus_addr[31:12] == 20'hFFFFF`; every other address is DRAM.
  - `dram_wen = Bus_wen & ~peripheral`.
  - For DRAM accesses, `Bus_rdata = dram_rdata`.
- **Peripheral map.** Offsets are `Bus_addr[11:0]`; the low two address bits are ignored.
  - 0x000 DIGIT: read/write, 32 bits; nibble *k* drives display digit *k*.
  - 0x020 TCNT: read/write, 32 bits; timer count. A write loads the count.
  - 0x024 TDIV: read/write, 32 bits; prescaler divisor. A value of 0 behaves as 1.
  - 0x060 LED: read/write; uses `Bus_wdata[23:0]` and reads back zero-extended.
  - 0x070 SW: read-only; the synchronized `sw`, zero-extended.
  - 0x078 BTN: read-only; the synchronized `btn`, zero-extended.
  - Any other offset in the page reads 0, and writes to it are ignored. Writes to SW and BTN are ignored.
- **Reads.** A read returns the register's value before any write in the same cycle; there is no write-to-read bypass.
- **Timer.**
  - A prescale counter `pcnt` counts from 0 up to max(TDIV,1)−1.
  - On the cycle where `pcnt` is at that limit, `pcnt` returns to 0 and TCNT increments, wrapping 0xFFFFFFFF→0.
  - A TCNT write overrides an increment in the same cycle, and also clears `pcnt`.
  - A TDIV write clears `pcnt`; the new divisor applies from the next cycle.
- **Synchronizers.** `sw` and `btn` each pass through two flops before they are visible to reads.
- **Scan driver.**
  - `scnt` counts 0..SCAN_DIV−1; when it wraps, `sidx` advances modulo 8.
  - Every cycle out of reset, `seg_en <= ~(8'b1 << sidx)` and `seg_code <=` hex decode of `DIGIT[4*sidx+3 -: 4]`.
  - `dp` is always 1 (off).
  - Decode for 0..F, active-low: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.

## Timing
- **Reset.** While `rst` = 0 at a clock edge:
  - DIGIT, TCNT, TDIV, LED, `pcnt`, `scnt`, `sidx` and both synchronizer stages are cleared to 0.
  - `seg_en` = 8'hFF and `seg_code` = 8'hFF.
  - Bus writes are ignored.
- **Reset mid-operation.** The reset clears everything listed above on that same edge, including a pending TCNT increment.
- **Read latency.** 0 cycles: `Bus_rdata` is combinational from the address and current state.
- **Write latency.** A write is visible to reads in the cycle after the `Bus_wen` cycle.
- **Display latency.**
  - `seg_en` and `seg_code` lag `sidx` and DIGIT by 1 cycle.
  - The first cycle after reset deasserts, they show digit 0.
- **Synchronizer latency.** A `sw` change is readable 2 edges later.
- **Timer period.** With TDIV = N ≥ 1, TCNT increments once every N cycles. The first increment after a TDIV write lands N edges after that write.

## Test plan
- **DRAM pass-through.** Write 0x12345678 to 0x00000104, then read 0x00000104 with `dram_rdata` = 0xCAFEBABE.
  - Write cycle: `dram_wen` = 1, `dram_addr` = 0x41.
  - Read cycle: `Bus_rdata` = 0xCAFEBABE.
- **LED write.** Write 0xFFABCDEF to 0xFFFFF060.
  - `led` = 0xABCDEF on the next cycle; a read returns 0x00ABCDEF; `dram_wen` stays 0.
  - A read of 0xFFFFF100 returns 0.
- **Timer prescale.** Write TDIV = 3, then TCNT = 10.
  - TCNT reads 10, 11, 12 at edges +0, +3, +6 after the TCNT write.
  - Write TCNT = 0xFFFFFFFF with TDIV = 1: the next read gives 0xFFFFFFFF and the one after gives 0 (wrap).
- **Write/increment collision.** Issue a TCNT write of 0x55 in the exact increment cycle.
  - TCNT = 0x55 afterwards, not 0x56, and the next increment lands 3 cycles later.
- **Synchronizers.** Step `sw` from 0 to 0xA5A5A5.
  - Reads of 0xFFFFF070 return 0 for 2 edges, then 0x00A5A5A5.
- **Scan and reset.** Set SCAN_DIV = 4 and DIGIT = 0x76543210.
  - `seg_en` steps FE, FD, FB, … every 4 cycles, with `seg_code` = C0, F9, A4, …
  - Assert `rst` low for one edge mid-scan: `seg_en` = FF, TCNT = 0, LED = 0.
  - After release, the scan restarts at digit 0.
